// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 resolves group carries through a flattened two-level lookahead; stage 2 finishes the in-group carries.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] bMux, pBit, gBit;
  logic             c0;
  logic [NG-1:0]    grpP, grpG;
  logic [NG:0]      grpC;

  logic             v1, v2;
  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0]    grpCin1;
  logic             cFinal1;

  logic [WIDTH-1:0] carries, sumNext;
  logic             adv1, adv2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v2;

  // NOTE: every variable written here gets a value before any branch or loop reads it, so no latch is inferred.
  always_comb begin : groupPg
    logic term;
    term = 1'b0;
    bMux = sub ? ~b : b;
    c0   = sub | cin;
    pBit = a ^ bMux;
    gBit = a & bMux;
    for (int k = 0; k < NG; k++) begin
      grpP[k] = 1'b1;
      grpG[k] = 1'b0;
      for (int q = 0; q < GROUP; q++) begin
        grpP[k] = grpP[k] & pBit[k*GROUP+q];
        term = gBit[k*GROUP+q];
        for (int r = q + 1; r < GROUP; r++) term = term & pBit[k*GROUP+r];
        grpG[k] = grpG[k] | term;
      end
    end
  end

  // Sum-of-products form of C[k+1] = G[k] | P[k]&C[k], so no group waits on its neighbour.
  always_comb begin : groupCarry
    logic acc, term;
    acc  = 1'b0;
    term = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      acc = c0;
      for (int j = 0; j < k; j++) acc = acc & grpP[j];
      for (int j = 0; j < k; j++) begin
        term = grpG[j];
        for (int m = j + 1; m < k; m++) term = term & grpP[m];
        acc = acc | term;
      end
      grpC[k] = acc;
    end
  end

  always_comb begin : localCarry
    logic acc, term;
    acc  = 1'b0;
    term = 1'b0;
    for (int k = 0; k < NG; k++) begin
      for (int q = 0; q < GROUP; q++) begin
        acc = grpCin1[k];
        for (int j = 0; j < q; j++) acc = acc & p1[k*GROUP+j];
        for (int j = 0; j < q; j++) begin
          term = g1[k*GROUP+j];
          for (int m = j + 1; m < q; m++) term = term & p1[k*GROUP+m];
          acc = acc | term;
        end
        carries[k*GROUP+q] = acc;
      end
    end
    sumNext = p1 ^ carries;
  end

  // NOTE: sequential state uses non-blocking assignments so both stages sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      p1      <= '0;
      g1      <= '0;
      grpCin1 <= '0;
      cFinal1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        p1      <= pBit;
        g1      <= gBit;
        grpCin1 <= grpC[NG-1:0];
        cFinal1 <= grpC[NG];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        sum  <= sumNext;
        cout <= cFinal1;
        ovf  <= carries[WIDTH-1] ^ cFinal1;
        zero <= ~|sumNext;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=32/GROUP=4: reset, carry/overflow corners,
// backpressure, mid-flight reset, then a short randomized stream against a reference model.
module tb_cla_pipe_adder;

  localparam int WIDTH = 32;
  localparam int GROUP = 4;

  logic             clk, rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;

  int errors = 0;
  int checks = 0;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                       input logic dc, input logic ds);
    in_valid = v;
    a = da;
    b = db;
    cin = dc;
    sub = ds;
  endtask

  // Returns {cout, ovf, zero, sum} from plain wide arithmetic.
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mc, input logic ms);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             o;
    bb   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (ms ? 1'b1 : mc)};
    o    = (ma[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return {full[WIDTH], o, (full[WIDTH-1:0] == '0), full[WIDTH-1:0]};
  endfunction

  task automatic run_one(input string tag, input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                         input logic dc, input logic ds, input logic [WIDTH-1:0] eSum,
                         input logic eCout, input logic eOvf, input logic eZero);
    out_ready = 1'b1;
    drive(1'b1, da, db, dc, ds);
    tick();
    check({tag, ".lat1"}, out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".sum"}, sum, eSum);
    check({tag, ".cout"}, cout, eCout);
    check({tag, ".ovf"}, ovf, eOvf);
    check({tag, ".zero"}, zero, eZero);
    tick();
  endtask

  logic [WIDTH+2:0] expQ[$];
  logic [WIDTH+2:0] exp;
  logic [WIDTH-1:0] ra, rb;
  int               budget;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);

    // Reset held for 3 cycles with a beat already presented.
    repeat (3) tick();
    check("rst.valid", out_valid, 1'b0);
    check("rst.sum", sum, 32'h0);
    check("rst.cout", cout, 1'b0);
    check("rst.ovf", ovf, 1'b0);
    check("rst.zero", zero, 1'b0);
    check("rst.ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();
    check("first.lat1", out_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    check("first.valid", out_valid, 1'b1);
    check("first.sum", sum, 32'h0);
    check("first.cout", cout, 1'b1);
    check("first.zero", zero, 1'b1);
    check("first.ovf", ovf, 1'b0);
    tick();

    run_one("prop2", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_one("ovfadd", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("ovfsub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("noborrow", 32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    run_one("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0);
    run_one("subeq", 32'h1234, 32'h1234, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure: two beats fill the pipe, the third waits until out_ready returns.
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
    #1;
    check("bp.ready1", in_ready, 1'b1);
    tick();
    drive(1'b1, 32'd2, 32'd2, 1'b0, 1'b0);
    #1;
    check("bp.ready2", in_ready, 1'b1);
    tick();
    drive(1'b1, 32'd3, 32'd3, 1'b0, 1'b0);
    #1;
    check("bp.full", in_ready, 1'b0);
    check("bp.valid", out_valid, 1'b1);
    check("bp.sum1", sum, 32'd2);
    tick();
    check("bp.hold", sum, 32'd2);
    check("bp.stillfull", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.readycomb", in_ready, 1'b1);
    tick();
    check("bp.sum2", sum, 32'd4);
    drive(1'b1, 32'd4, 32'd4, 1'b0, 1'b0);
    tick();
    check("bp.sum3", sum, 32'd6);
    check("bp.v3", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    check("bp.sum4", sum, 32'd8);
    check("bp.v4", out_valid, 1'b1);
    tick();
    check("bp.drained", out_valid, 1'b0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    drive(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
    tick();
    check("mid.valid", out_valid, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid.asyncvalid", out_valid, 1'b0);
    check("mid.asyncsum", sum, 32'h0);
    check("mid.ready", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("mid.after1", out_valid, 1'b0);
    tick();
    check("mid.after2", out_valid, 1'b0);

    // Randomized stream with random backpressure against the wide-arithmetic model.
    for (int n = 0; n < 2000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 7 == 0) rb = ~ra;
      drive(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd.ready", in_ready, (expQ.size() < 2) || out_ready);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) check("rnd.spurious", out_valid, 1'b0);
        else begin
          exp = expQ.pop_front();
          check("rnd.result", {cout, ovf, zero, sum}, exp);
        end
      end
      if (in_valid && in_ready) expQ.push_back(model(a, b, cin, sub));
      tick();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (expQ.size() != 0 && budget < 10) begin
      #1;
      if (out_valid) begin
        exp = expQ.pop_front();
        check("drain.result", {cout, ovf, zero, sum}, exp);
      end
      tick();
      budget++;
    end
    check("drain.empty", 64'(expQ.size()), 64'd0);
    #1;
    check("drain.idle", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
